// File: rtl/turn_countdown_timer.sv
// Per-turn countdown: counts 1 ms ticks into whole seconds and pulses Timeout at zero.
// Optional feature macro TURN_TIMER_PAUSE_EN adds a Pause input that holds the count while in RUN.
module turn_countdown_timer #(
    parameter int MS_PER_SEC = 1000,
    parameter int SEC_W      = 8,
    parameter int WARN_SEC   = 3
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Tick1ms,
    input  logic             Start,
    input  logic             Stop,
`ifdef TURN_TIMER_PAUSE_EN
    input  logic             Pause,
`endif
    input  logic [SEC_W-1:0] Limit,
    output logic             Running,
    output logic             Timeout,
    output logic [SEC_W-1:0] SecLeft,
    output logic             Warn
);

    localparam int MS_W = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
    localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(MS_PER_SEC - 1);
    localparam logic [SEC_W-1:0] WARN_LIM = SEC_W'(WARN_SEC);
    localparam logic [SEC_W-1:0] ONE_SEC  = SEC_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [MS_W-1:0]  ms_q, ms_d;
    logic             running_q, running_d;
    logic             timeout_q, timeout_d;
    logic             warn_q, warn_d;
    logic             hold;

`ifdef TURN_TIMER_PAUSE_EN
    assign hold = Pause;
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        sec_d     = sec_q;
        ms_d      = ms_q;
        running_d = running_q;
        timeout_d = 1'b0;

        // Stop outranks both Start and a coincident final tick.
        if (Stop) begin
            if (state_q == RUN) begin
                state_d   = IDLE;
                running_d = 1'b0;
            end
        end else if (Start) begin
            ms_d = '0;
            if (Limit == '0) begin
                state_d   = EXPIRED;
                sec_d     = '0;
                running_d = 1'b0;
                timeout_d = 1'b1;
            end else begin
                state_d   = RUN;
                sec_d     = Limit;
                running_d = 1'b1;
            end
        end else if (state_q == RUN && Tick1ms && !hold) begin
            if (ms_q == MS_LAST) begin
                ms_d  = '0;
                sec_d = sec_q - ONE_SEC;
                if (sec_q == ONE_SEC) begin
                    state_d   = EXPIRED;
                    running_d = 1'b0;
                    timeout_d = 1'b1;
                end
            end else begin
                ms_d = ms_q + MS_W'(1);
            end
        end

        // Warn is computed from next-state values so it lines up with SecLeft.
        warn_d = (sec_d != '0) && (sec_d <= WARN_LIM) && running_d;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= IDLE;
            sec_q     <= '0;
            ms_q      <= '0;
            running_q <= 1'b0;
            timeout_q <= 1'b0;
            warn_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sec_q     <= sec_d;
            ms_q      <= ms_d;
            running_q <= running_d;
            timeout_q <= timeout_d;
            warn_q    <= warn_d;
        end
    end

    assign Running = running_q;
    assign Timeout = timeout_q;
    assign SecLeft = sec_q;
    assign Warn    = warn_q;

endmodule

// File: tb/tb_turn_countdown_timer.sv
// Directed bench for turn_countdown_timer with MS_PER_SEC=4, WARN_SEC=3.
module tb_turn_countdown_timer;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Tick1ms = 1'b0;
    logic       Start = 1'b0;
    logic       Stop = 1'b0;
    logic [7:0] Limit = 8'd0;
    logic       Running, Timeout, Warn;
    logic [7:0] SecLeft;
`ifdef TURN_TIMER_PAUSE_EN
    logic       Pause = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    turn_countdown_timer #(.MS_PER_SEC(4), .SEC_W(8), .WARN_SEC(3)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Tick1ms (Tick1ms),
        .Start   (Start),
        .Stop    (Stop),
`ifdef TURN_TIMER_PAUSE_EN
        .Pause   (Pause),
`endif
        .Limit   (Limit),
        .Running (Running),
        .Timeout (Timeout),
        .SecLeft (SecLeft),
        .Warn    (Warn)
    );

    always #5 Clk = ~Clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        Tick1ms = 1'b1;
        step();
        Tick1ms = 1'b0;
    endtask

    task automatic start_with(input logic [7:0] lim);
        Limit = lim;
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic run, input logic to,
                              input logic [7:0] sec, input logic wrn);
        check_vec({tag, ".Running"}, 32'(Running), 32'(run));
        check_vec({tag, ".Timeout"}, 32'(Timeout), 32'(to));
        check_vec({tag, ".SecLeft"}, 32'(SecLeft), 32'(sec));
        check_vec({tag, ".Warn"},    32'(Warn),    32'(wrn));
    endtask

    initial begin
        logic [7:0] es;
        logic       er;

        // Reset state
        step();
        check_outs("reset", 1'b0, 1'b0, 8'd0, 1'b0);
        Rst = 1'b1;
        step();
        check_outs("idle", 1'b0, 1'b0, 8'd0, 1'b0);

        // Ticks in IDLE do nothing
        tick(); tick();
        check_outs("idle_tick", 1'b0, 1'b0, 8'd0, 1'b0);

        // Test 1: async reset mid-RUN
        start_with(8'd5);
        check_outs("t1_start", 1'b1, 1'b0, 8'd5, 1'b0);
        tick(); tick(); tick(); tick(); tick();
        check_outs("t1_run", 1'b1, 1'b0, 8'd4, 1'b0);
        #2 Rst = 1'b0;
        #1;
        check_outs("t1_async", 1'b0, 1'b0, 8'd0, 1'b0);
        tick();
        check_outs("t1_rst_tick", 1'b0, 1'b0, 8'd0, 1'b0);
        Rst = 1'b1;
        tick(); tick(); tick(); tick();
        check_outs("t1_idle", 1'b0, 1'b0, 8'd0, 1'b0);

        // Test 2: full countdown from 5
        start_with(8'd5);
        check_outs("t2_start", 1'b1, 1'b0, 8'd5, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            es = 8'(5 - k / 4);
            er = (k < 20);
            check_outs($sformatf("t2_k%0d", k), er, (k == 20), es,
                       er && (es >= 8'd1) && (es <= 8'd3));
            step();
        end
        check_outs("t2_after", 1'b0, 1'b0, 8'd0, 1'b0);
        tick(); tick(); tick(); tick();
        check_outs("t2_expired_tick", 1'b0, 1'b0, 8'd0, 1'b0);

        // Test 3: Stop after 9 ticks freezes at 3
        start_with(8'd5);
        for (int k = 0; k < 9; k++) tick();
        check_outs("t3_pre", 1'b1, 1'b0, 8'd3, 1'b1);
        Stop = 1'b1;
        step();
        Stop = 1'b0;
        check_outs("t3_stop", 1'b0, 1'b0, 8'd3, 1'b0);
        for (int k = 0; k < 8; k++) tick();
        check_outs("t3_frozen", 1'b0, 1'b0, 8'd3, 1'b0);

        // Test 4: Limit=0 expires immediately
        start_with(8'd0);
        check_outs("t4_start", 1'b0, 1'b1, 8'd0, 1'b0);
        step();
        check_outs("t4_after", 1'b0, 1'b0, 8'd0, 1'b0);

        // Test 5: Stop coincident with final tick, then Start+Stop in IDLE
        start_with(8'd2);
        for (int k = 0; k < 7; k++) tick();
        check_outs("t5_pre", 1'b1, 1'b0, 8'd1, 1'b1);
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        check_outs("t5_stop", 1'b0, 1'b0, 8'd1, 1'b0);
        step();
        check_outs("t5_hold", 1'b0, 1'b0, 8'd1, 1'b0);
        Stop = 1'b1;
        start_with(8'd4);
        Stop = 1'b0;
        check_outs("t5_both", 1'b0, 1'b0, 8'd1, 1'b0);

        // Restart mid-RUN reloads seconds and clears the ms count
        start_with(8'd5);
        tick(); tick(); tick();
        start_with(8'd2);
        check_outs("rs_start", 1'b1, 1'b0, 8'd2, 1'b1);
        tick();
        check_outs("rs_tick1", 1'b1, 1'b0, 8'd2, 1'b1);
        tick(); tick(); tick();
        check_outs("rs_tick4", 1'b1, 1'b0, 8'd1, 1'b1);

`ifdef TURN_TIMER_PAUSE_EN
        // Test 6: Pause holds the count
        start_with(8'd2);
        tick(); tick();
        Pause = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        check_outs("t6_paused", 1'b1, 1'b0, 8'd2, 1'b1);
        Pause = 1'b0;
        tick(); tick();
        check_outs("t6_sec1", 1'b1, 1'b0, 8'd1, 1'b1);
        tick(); tick(); tick();
        check_outs("t6_pre", 1'b1, 1'b0, 8'd1, 1'b1);
        tick();
        check_outs("t6_timeout", 1'b0, 1'b1, 8'd0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
